bus_bridge_ws: RTL

//   CPU-to-memory/peripheral bus bridge with wait-state handshake. Decodes each CPU request to

---
 rtl/bus_bridge_ws.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bus_bridge_ws.sv
// CPU-to-DRAM/peripheral bridge with wait-state handshake and registered response.
// Optional wait timeout enabled by defining BRIDGE_TIMEOUT_EN.
module bus_bridge_ws #(
    parameter int unsigned N_SLOTS   = 8,
    parameter logic [19:0] PERI_PAGE = 20'hFFFFF,
    parameter logic [31:0] DEAD_DATA = 32'hDEADBFEE,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                   clk_from_cpu,
    input  logic                   rst_from_cpu,
    input  logic                   req_from_cpu,
    input  logic                   we_from_cpu,
    input  logic [31:0]            addr_from_cpu,
    input  logic [31:0]            wdata_from_cpu,
    output logic [31:0]            rdata_to_cpu,
    output logic                   ready_to_cpu,
    output logic                   err_to_cpu,
    output logic                   req_to_dram,
    output logic                   we_to_dram,
    output logic [31:0]            addr_to_dram,
    output logic [31:0]            wdata_to_dram,
    input  logic [31:0]            rdata_from_dram,
    input  logic                   ready_from_dram,
    output logic [N_SLOTS-1:0]     sel_to_periph,
    output logic                   we_to_periph,
    output logic [31:0]            wdata_to_periph,
    input  logic [32*N_SLOTS-1:0]  rdata_from_periph,
    input  logic [N_SLOTS-1:0]     ready_from_periph
);

    typedef enum logic [1:0] {StIdle, StMem, StPeri, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [5:0]  slot_q, slot_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    logic        page_hit;
    logic        slot_ok;
    logic [31:0] periph_rdata;
    logic        periph_ready;
    logic        tgt_ready;
    logic [31:0] tgt_rdata;

    assign page_hit = (addr_from_cpu[31:12] == PERI_PAGE);
    assign slot_ok  = (addr_from_cpu[1:0] == 2'b00) &&
                      ({22'd0, addr_from_cpu[11:2]} < N_SLOTS);

    // Only the latched slot's ready and data are ever looked at.
    always_comb begin
        periph_rdata = '0;
        periph_ready = 1'b0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (slot_q == 6'(k)) begin
                periph_rdata = rdata_from_periph[32*k +: 32];
                periph_ready = ready_from_periph[k];
            end
        end
    end

    assign tgt_ready = (state_q == StMem) ? ready_from_dram : periph_ready;
    assign tgt_rdata = (state_q == StMem) ? rdata_from_dram : periph_rdata;

    always_ff @(posedge clk_from_cpu or negedge rst_from_cpu) begin
        if (!rst_from_cpu) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            slot_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            slot_q  <= slot_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        slot_d  = slot_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_from_cpu) begin
                    addr_d  = addr_from_cpu;
                    wdata_d = wdata_from_cpu;
                    we_d    = we_from_cpu;
`ifdef BRIDGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (!page_hit) begin
                        state_d = StMem;
                    end else if (slot_ok) begin
                        slot_d  = addr_from_cpu[7:2];
                        state_d = StPeri;
                    end else begin
                        rdata_d = DEAD_DATA;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StMem, StPeri: begin
                if (tgt_ready) begin
                    rdata_d = we_q ? 32'd0 : tgt_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
`ifdef BRIDGE_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    rdata_d = DEAD_DATA;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ready_to_cpu    = (state_q == StResp);
        err_to_cpu      = (state_q == StResp) && err_q;
        rdata_to_cpu    = rdata_q;
        req_to_dram     = (state_q == StMem);
        we_to_dram      = (state_q == StMem) && we_q;
        addr_to_dram    = addr_q;
        wdata_to_dram   = wdata_q;
        we_to_periph    = (state_q == StPeri) && we_q;
        wdata_to_periph = wdata_q;
        sel_to_periph   = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            sel_to_periph[k] = (state_q == StPeri) && (slot_q == 6'(k));
        end
    end

endmodule
